// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
module uart_tx_serializer #(
    parameter int unsigned C_CLK_FREQ        = 100_000_000,
    parameter int unsigned C_UART_RATE       = 115_200,
    parameter int unsigned C_UART_DATA_WIDTH = 8,
    parameter int unsigned C_UART_PARITY     = 0,
    parameter int unsigned C_UART_STOP_BITS  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         send,
    input  logic [C_UART_DATA_WIDTH-1:0] data,
    output logic                         busy,
    output logic                         err,
    output logic                         tx
);

    localparam int unsigned C_BIT_CLKS = C_CLK_FREQ / C_UART_RATE;
    localparam int unsigned STOP_CLKS  = C_UART_STOP_BITS * C_BIT_CLKS;
    localparam int unsigned CNT_W      = (STOP_CLKS < 2) ? 1 : $clog2(STOP_CLKS);
    localparam int unsigned BIT_W      = $clog2(C_UART_DATA_WIDTH);
    localparam int unsigned W          = C_UART_DATA_WIDTH;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(C_BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(W - 1);
    localparam logic             PAR_EN    = (C_UART_PARITY != 0);
    localparam logic             PAR_ODD   = (C_UART_PARITY == 1);

    // Reject parameter sets the serializer cannot honour.
    if (C_BIT_CLKS < 2) begin : g_bad_rate
        $fatal(1, "uart_tx_serializer: C_CLK_FREQ / C_UART_RATE must be at least 2");
    end
    if (W < 5 || W > 9) begin : g_bad_width
        $fatal(1, "uart_tx_serializer: C_UART_DATA_WIDTH must be 5..9");
    end
    if (C_UART_PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx_serializer: C_UART_PARITY must be 0, 1 or 2");
    end
    if (C_UART_STOP_BITS < 1 || C_UART_STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "uart_tx_serializer: C_UART_STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q,  baud_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [W-1:0]     shift_q, shift_d;
    logic             par_q,   par_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             err_q,   err_d;

    // State and output registers with synchronous reset; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counters, and the values the output flops take next cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        err_d   = err_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (send) begin
                    shift_d = data;
                    par_d   = (^data) ^ PAR_ODD;
                    err_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == STOP_LAST) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // A request while a frame is running is dropped but remembered.
        if (busy_q && send) begin
            err_d = 1'b1;
        end

        // Outputs follow the state being entered so they line up with it.
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: three serializers (none/1 stop, even/1 stop, odd/2 stop) share inputs.
module tb_uart_tx_serializer;

    localparam int BIT_CLKS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] data;
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] err_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .C_CLK_FREQ(100_000_000), .C_UART_RATE(10_000_000), .C_UART_DATA_WIDTH(8),
        .C_UART_PARITY(0), .C_UART_STOP_BITS(1)
    ) u_none (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .busy(busy_w[0]), .err(err_w[0]), .tx(tx_w[0])
    );

    uart_tx_serializer #(
        .C_CLK_FREQ(100_000_000), .C_UART_RATE(10_000_000), .C_UART_DATA_WIDTH(8),
        .C_UART_PARITY(2), .C_UART_STOP_BITS(1)
    ) u_even (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .busy(busy_w[1]), .err(err_w[1]), .tx(tx_w[1])
    );

    uart_tx_serializer #(
        .C_CLK_FREQ(100_000_000), .C_UART_RATE(10_000_000), .C_UART_DATA_WIDTH(8),
        .C_UART_PARITY(1), .C_UART_STOP_BITS(2)
    ) u_odd2 (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .busy(busy_w[2]), .err(err_w[2]), .tx(tx_w[2])
    );

    function automatic logic [2:0] obs(input int sel);
        return {tx_w[sel], busy_w[sel], err_w[sel]};
    endfunction

    // Wait (bounded) until every instance is idle.
    task automatic wait_idle();
        int n = 0;
        while (busy_w != 3'b000 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy_w !== 3'b000) begin
            miscompares++;
            $display("FAIL wait_idle: busy=%b required 000", busy_w);
        end
    endtask

    // One-cycle send pulse; returns at the first cycle of the new frame.
    task automatic send_pulse(input logic [7:0] d);
        @(negedge clk);
        send = 1'b1;
        data = d;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Checks {tx,busy,err} on every cycle of a frame, starting at its first cycle.
    task automatic check_frame(input int sel, input logic [7:0] d, input int inject_at,
                               input bit held, input int abort_at, input string name);
        logic [11:0] seq;
        logic [2:0]  exp;
        int          nb;
        logic        e;
        seq = 12'hFFF;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1+i] = d[i];
        nb = 10;
        if (sel == 1) begin seq[9] = ^d;  nb = 11; end
        if (sel == 2) begin seq[9] = ~^d; nb = 12; end
        for (int k = 0; k < nb * BIT_CLKS; k++) begin
            if (k > 0) @(negedge clk);
            if (inject_at >= 0 && k == inject_at + 1) begin
                send = 1'b0;
                data = 8'h00;
            end
            e   = (inject_at >= 0 && k > inject_at) || (held && k >= 1);
            exp = {seq[k / BIT_CLKS], 1'b1, e};
            vectors++;
            if (obs(sel) !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: tx/busy/err=%b required %b", name, k, obs(sel), exp);
            end
            if (k == inject_at) begin
                send = 1'b1;
                data = 8'hFF;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                vectors++;
                if (obs(sel) !== 3'b100) begin
                    miscompares++;
                    $display("FAIL %s abort: tx/busy/err=%b required 100", name, obs(sel));
                end
                return;
            end
        end
        @(negedge clk);
        exp = {1'b1, 1'b0, (inject_at >= 0) || held};
        vectors++;
        if (obs(sel) !== exp) begin
            miscompares++;
            $display("FAIL %s idle gap: tx/busy/err=%b required %b", name, obs(sel), exp);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        send = 1'b0;
        data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            vectors++;
            if ({tx_w, busy_w, err_w} !== 9'b111_000_000) begin
                miscompares++;
                $display("FAIL reset idle cycle %0d: tx/busy/err=%b required 111000000",
                         k, {tx_w, busy_w, err_w});
            end
        end
    endtask

    task automatic test_frame_none();
        send_pulse(8'hA5);
        check_frame(0, 8'hA5, -1, 1'b0, -1, "none_A5");
        wait_idle();
    endtask

    task automatic test_parity();
        logic [11:0] hand_seq;
        send_pulse(8'hA5);
        check_frame(1, 8'hA5, -1, 1'b0, -1, "even_A5");
        wait_idle();
        send_pulse(8'hA5);
        // Hand-checked odd-parity bit for 0xA5 (four ones -> 1) at the parity slot.
        hand_seq = 12'b1111_0000_0000;
        repeat (9 * BIT_CLKS + 4) @(negedge clk);
        vectors++;
        if (tx_w[2] !== hand_seq[11]) begin
            miscompares++;
            $display("FAIL odd_parity_bit: tx=%b required %b", tx_w[2], hand_seq[11]);
        end
        wait_idle();
        send_pulse(8'hA5);
        check_frame(2, 8'hA5, -1, 1'b0, -1, "odd2_A5");
        wait_idle();
    endtask

    task automatic test_err();
        send_pulse(8'hA5);
        check_frame(0, 8'hA5, 30, 1'b0, -1, "err_A5");
        wait_idle();
        vectors++;
        if (err_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b required 1", err_w[0]);
        end
        send_pulse(8'h3C);
        check_frame(0, 8'h3C, -1, 1'b0, -1, "clear_3C");
        wait_idle();
    endtask

    task automatic test_reset_abort();
        send_pulse(8'hA5);
        check_frame(0, 8'hA5, -1, 1'b0, 40, "abort_A5");
        send_pulse(8'h55);
        check_frame(0, 8'h55, -1, 1'b0, -1, "after_abort_55");
        wait_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send = 1'b1;
        data = 8'h01;
        @(negedge clk);
        data = 8'h02;
        check_frame(0, 8'h01, -1, 1'b1, -1, "b2b_01");
        @(negedge clk);
        data = 8'h03;
        check_frame(0, 8'h02, -1, 1'b1, -1, "b2b_02");
        @(negedge clk);
        send = 1'b0;
        check_frame(0, 8'h03, -1, 1'b0, -1, "b2b_03");
        @(negedge clk);
        vectors++;
        if (obs(0) !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_final_idle: tx/busy/err=%b required 100", obs(0));
        end
        wait_idle();
    endtask

    initial begin
        rst  = 1'b1;
        send = 1'b0;
        data = 8'h00;
        test_reset();
        test_frame_none();
        test_parity();
        test_err();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
